// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 output pins from the SPI register file
// configuration. Each pin is held low, driven static high, or follows one
// shared 8-bit PWM waveform. The duty cycle is double-buffered so that a new
// value only takes effect at a period boundary.

module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  // With CLK_DIV == 1 the terminal count is 0, so the prescaler stays at 0
  // and every cycle is a tick.
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [15:0] prescaler;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_active;
  logic        tick;
  logic        wrap;
  logic        pwm_raw;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign tick    = (prescaler == DIV_LAST);
  assign wrap    = tick && (pwm_cnt == 8'hFF);
  // Full scale is special-cased so 0xFF stays high with no one-tick gap.
  assign pwm_raw = (duty_active == 8'hFF) || (pwm_cnt < duty_active);

  // Prescaler: divides the system clock down to one PWM tick per CLK_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

  // Period counter and duty shadow: the duty request is only latched on wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt     <= '0;
      duty_active <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) begin
        duty_active <= pwm_duty_cycle;
      end
    end
  end

  // Period marker: one-cycle pulse in the first cycle of each new period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
    end
  end

  // Registered pin mux: output enable gates everything, PWM mode selects waveform.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= en_out & (~en_pwm | {16{pwm_raw}});
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: three instances of pwm_peripheral (CLK_DIV 4, 1, 2) share
// one set of randomized and directed inputs. A reference model tracks time
// since reset and derives counter, duty shadow and pin levels arithmetically.

module tb_pwm_peripheral;

  localparam int NDUT = 3;

  logic        clk;
  logic        rst;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] outs [NDUT];
  logic        ps   [NDUT];

  int testCount;
  int failCount;

  function automatic int unsigned divOf(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    pwm_peripheral #(
      .CLK_DIV((g == 0) ? 4 : ((g == 1) ? 1 : 2))
    ) dut (
      .clk             (clk),
      .rst             (rst),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .out             (outs[g]),
      .period_start    (ps[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: edges since reset, latched duty, expected outputs.
  int unsigned tCnt   [NDUT];
  logic [7:0]  dutyM  [NDUT];
  logic [15:0] expOut [NDUT];
  logic        expPs  [NDUT];
  int unsigned mD;
  int unsigned mCnt;
  logic        mRaw;

  // Model: after t edges the counter is (t / CLK_DIV) mod 256 and a new
  // period begins on every edge where t is a multiple of 256*CLK_DIV.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        tCnt[i]   = 0;
        dutyM[i]  = 8'h00;
        expOut[i] = 16'h0000;
        expPs[i]  = 1'b0;
      end else begin
        mD   = divOf(i);
        mCnt = (tCnt[i] / mD) % 256;
        mRaw = (dutyM[i] == 8'hFF) || (mCnt < 32'(dutyM[i]));
        expOut[i] = {en_reg_out_15_8, en_reg_out_7_0} &
                    (~{en_reg_pwm_15_8, en_reg_pwm_7_0} | {16{mRaw}});
        tCnt[i] = tCnt[i] + 1;
        if ((tCnt[i] % (256 * mD)) == 0) begin
          dutyM[i] = pwm_duty_cycle;
          expPs[i] = 1'b1;
        end else begin
          expPs[i] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] eo, input logic [15:0] ep,
                               input logic [7:0] duty);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    pwm_duty_cycle = duty;
  endtask

  task automatic compareAll();
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("out%0d", i), outs[i], expOut[i]);
      checkOutput($sformatf("period_start%0d", i), {15'b0, ps[i]}, {15'b0, expPs[i]});
    end
  endtask

  task automatic runCycles(input int n, input int dutyPct, input int enPct);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      compareAll();
      if ($urandom_range(0, 99) < dutyPct) begin
        pwm_duty_cycle = 8'($urandom);
      end
      if ($urandom_range(0, 99) < enPct) begin
        {en_reg_out_15_8, en_reg_out_7_0} = 16'($urandom);
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = 16'($urandom);
      end
    end
  endtask

  initial begin
    logic        found;
    logic [15:0] prevOut;

    testCount = 0;
    failCount = 0;
    rst = 1'b1;
    applyStimulus(16'h0000, 16'h0000, 8'h00);

    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("reset_out%0d", i), outs[i], 16'h0000);
      checkOutput($sformatf("reset_ps%0d", i), {15'b0, ps[i]}, 16'h0000);
    end
    rst = 1'b0;

    // Static-high low byte, PWM waveform not selected anywhere.
    applyStimulus(16'h00FF, 16'h0000, 8'h55);
    runCycles(2100, 0, 0);

    // 50% duty on every pin.
    applyStimulus(16'hFFFF, 16'hFFFF, 8'h80);
    runCycles(3100, 0, 0);

    // Extremes.
    pwm_duty_cycle = 8'h00;
    runCycles(800, 0, 0);
    pwm_duty_cycle = 8'hFF;
    runCycles(800, 0, 0);
    pwm_duty_cycle = 8'h01;
    runCycles(800, 0, 0);

    // Mid-period update of the duty request.
    pwm_duty_cycle = 8'h40;
    runCycles(1300, 0, 0);
    pwm_duty_cycle = 8'hC0;
    runCycles(1300, 0, 0);

    // Duty changing every cycle, so wrap-cycle writes are exercised.
    runCycles(1200, 100, 0);

    // Mixed random enables and duty.
    runCycles(4000, 3, 1);

    // Enable override while the upper byte is high.
    applyStimulus(16'hFFFF, 16'hFFFF, 8'h80);
    found   = 1'b0;
    prevOut = 16'hFFFF;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(negedge clk);
      compareAll();
      if (outs[0] == 16'hFFFF && prevOut != 16'hFFFF) found = 1'b1;
      prevOut = outs[0];
    end
    checkOutput("override_wait", {15'b0, found}, 16'h0001);
    en_reg_out_15_8 = 8'h00;
    @(negedge clk);
    compareAll();
    checkOutput("override_hi", {8'h00, outs[0][15:8]}, 16'h0000);
    checkOutput("override_lo", {8'h00, outs[0][7:0]}, 16'h00FF);
    runCycles(600, 0, 0);

    // Asynchronous reset while every pin is high.
    applyStimulus(16'hFFFF, 16'hFFFF, 8'hFF);
    runCycles(4200, 0, 0);
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("pre_reset_out%0d", i), outs[i], 16'hFFFF);
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("async_out%0d", i), outs[i], 16'h0000);
      checkOutput($sformatf("async_ps%0d", i), {15'b0, ps[i]}, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;
    runCycles(1100, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Downstream consumer of the SPI register file: takes the five configuration bytes (output enables, PWM-mode enables, duty cycle) and drives 16 output pins.
- Each pin is forced low, driven static high, or driven by one shared 8-bit PWM waveform.
- An internal prescaler plus an 8-bit period counter set the PWM frequency: about 3 kHz at the 10 MHz system clock with the default parameter.
- Duty-cycle changes are double-buffered and take effect only at a period boundary, so no glitched periods occur.

Parameters:
- CLK_DIV, 13, system clocks per PWM tick. Legal range 1..65535. PWM period = 256*CLK_DIV clocks.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- en_reg_out_7_0  input  8  output enable, pins 7..0
- en_reg_out_15_8  input  8  output enable, pins 15..8
- en_reg_pwm_7_0  input  8  PWM-mode select, pins 7..0
- en_reg_pwm_15_8  input  8  PWM-mode select, pins 15..8
- pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
- out  output  16  pin drive, out[i] is pin i
- period_start  output  1  one-clock pulse at the first cycle of each PWM period

Behaviour:
- Reset (async assert, sync release): out=0, period_start=0, prescaler=0, pwm_cnt=0, duty_active=0.
- Inputs are already synchronous to clk; no synchronizers are required.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 when prescaler==CLK_DIV-1.
  - CLK_DIV=1 means tick every cycle; the prescaler register is then unused or constant 0.
- Period counter pwm_cnt, 8 bits:
  - Increments on tick.
  - On tick with pwm_cnt==255: wraps to 0, loads duty_active<=pwm_duty_cycle, and sets period_start=1 on the next cycle only.
- Duty shadow:
  - duty_active changes only on the wrap event above.
  - A pwm_duty_cycle change mid-period has no effect until the next wrap.
  - After reset, duty_active=0, so PWM pins stay low for the first full period.
- PWM waveform:
  - pwm_raw = (duty_active==8'hFF) OR (pwm_cnt < duty_active).
  - 0x00 gives constant low. 0xFF gives constant high (no 1-tick gap).
  - Any other value N gives N ticks high, starting at pwm_cnt=0, then 256-N ticks low.
- Pin mux, registered, with en_out={en_reg_out_15_8,en_reg_out_7_0} and en_pwm={en_reg_pwm_15_8,en_reg_pwm_7_0}:
  - out[i] <= en_out[i] & (~en_pwm[i] | pwm_raw).
  - en_out=0 forces low regardless of en_pwm.
  - en_out=1 with en_pwm=0 gives static high.
  - en_out=1 with en_pwm=1 gives PWM.
- Latency:
  - Enable changes reach out exactly 1 clk after they are sampled.
  - pwm_raw (from current pwm_cnt/duty_active) reaches out 1 clk later.
  - Therefore out for a PWM pin rises 1 clk after pwm_cnt becomes 0. period_start is aligned with that same edge.
- Simultaneous events: a duty write in the same cycle as the wrap tick is captured (duty_active takes the new value). Enable changes apply in every cycle, independent of period boundaries.
- Reset mid-period: counters, duty_active and out clear immediately. The restart behaves exactly as after power-on.
- No combinational path from any input to out.

Test Plan:
- Reset then static pins (CLK_DIV=4): en_reg_out_7_0=0xFF, en_reg_pwm_7_0=0x00 -> out=16'h00FF from the 2nd clk after the write; out[15:8]=0; period_start pulses every 1024 clks.
- 50% duty (CLK_DIV=4): en_out=0xFFFF, en_pwm=0xFFFF, duty=0x80 before the first wrap -> from the second period on, out=0xFFFF for 512 clks and 0x0000 for 512 clks per 1024-clk period, rising 1 clk after pwm_cnt wraps; first period all low.
- Extremes (CLK_DIV=1): duty=0x00 -> PWM pins constantly 0 over 3 periods. duty=0xFF -> constantly 1 with no single-cycle dips. duty=0x01 -> exactly 1 clk high per 256-clk period.
- Mid-period update (CLK_DIV=2): duty 0x40->0xC0 written at pwm_cnt=100 -> current period keeps 128 high clks; next period has 384 high clks; write in the wrap-tick cycle is captured the same wrap.
- Enable override: PWM running at duty 0x80, clear en_reg_out_15_8 while out[15:8] is high -> out[15:8]=0 exactly 1 clk later; out[7:0] unaffected.
- Async reset mid-period: assert rst between clock edges while out=0xFFFF -> out=0 and period_start=0 immediately without a clock edge; after release, the first period is low and pwm_cnt restarts from 0.
